// File: rtl/spi_reg_pkg.sv
// Shared encodings and constants for the SPI write-only register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam int         HDR_WR_BIT    = 7;
  localparam logic [7:0] FRAME_LEN_MAX = 8'd255;

endpackage

// File: rtl/spi_cs_sync.sv
// Brings the raw active-low chip select into clk and flags its rising edge (end of frame).
module spi_cs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  output logic cs_rise
);

  // Bit 0 is the first flop; idle-high preset so reset never fakes an edge.
  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], cs};
    end
  end

  assign cs_rise = ~sync_reg[2] & sync_reg[1];

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only register bank: header byte selects start address, data bytes auto-increment.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  cs,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_done,
  output logic [7:0]            frame_len,
  output logic                  frame_err
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic              cs_rise;
  logic              hdr_ok;
  logic              do_write;
  logic [7:0]        len_capture;
  logic              err_capture;

  spi_cs_sync u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .cs_rise (cs_rise)
  );

  assign hdr_ok = rx_data[HDR_WR_BIT] && ({1'b0, rx_data[6:0]} < NUM_REGS_B);

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    do_write    = 1'b0;
    len_capture = 8'd0;
    err_capture = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          if (hdr_ok) begin
            state_next = WRITE;
            ptr_next   = rx_data[ADDR_W-1:0];
            cnt_next   = 8'd0;
          end else begin
            state_next = DISCARD;
            err_next   = 1'b1;
          end
        end
      end
      WRITE: begin
        if (rx_valid) begin
          do_write = 1'b1;
          ptr_next = ptr_reg + 1'b1;
          cnt_next = (cnt_reg == FRAME_LEN_MAX) ? cnt_reg : cnt_reg + 8'd1;
        end
      end
      default: ;
    endcase

    // A byte coinciding with end of frame is accounted before the frame closes.
    len_capture = cnt_next;
    err_capture = err_next;

    if (cs_rise) begin
      state_next = IDLE;
      cnt_next   = 8'd0;
      err_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      cnt_reg    <= 8'd0;
      err_reg    <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      frame_done <= 1'b0;
      frame_len  <= 8'd0;
      frame_err  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
      wr_strobe  <= do_write;
      frame_done <= cs_rise;
      frame_err  <= cs_rise & err_capture;
      if (do_write) begin
        wr_addr <= ptr_reg;
        wr_data <= rx_data;
      end
      if (cs_rise) begin
        frame_len <= len_capture;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      logic [7:0] data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= 8'd0;
        end else if (do_write && (ptr_reg == ADDR_W'(gi))) begin
          data_reg <= rx_data;
        end
      end

      assign reg_out[gi*8 +: 8] = data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank (16 registers).
module tb_spi_reg_bank;

  logic         clk;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         cs;
  logic [127:0] reg_out;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         frame_done;
  logic [7:0]   frame_len;
  logic         frame_err;

  int           checks;
  int           failures;
  logic [127:0] model;

  spi_reg_bank #(.NUM_REGS(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cs         (cs),
    .reg_out    (reg_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_stb,
                           input logic [3:0] exp_addr, input string tag);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, "_stb"}, 128'(wr_strobe), 128'(exp_stb));
    if (exp_stb) begin
      model[exp_addr*8 +: 8] = b;
      chk({tag, "_addr"}, 128'(wr_addr), 128'(exp_addr));
      chk({tag, "_data"}, 128'(wr_data), 128'(b));
    end
    $display("tb: byte %s rx=%02h strobe=%0b addr=%0d data=%02h", tag, b, wr_strobe, wr_addr, wr_data);
  endtask

  task automatic end_frame(input logic [7:0] exp_len, input logic exp_err, input string tag);
    int n;
    @(negedge clk);
    cs = 1'b1;
    n  = 0;
    while (!frame_done && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(3));
    chk({tag, "_len"}, 128'(frame_len), 128'(exp_len));
    chk({tag, "_err"}, 128'(frame_err), 128'(exp_err));
    $display("tb: frame %s done_after=%0d len=%0d err=%0b", tag, n, frame_len, frame_err);
    @(negedge clk);
    chk({tag, "_pulse"}, 128'(frame_done), 128'(0));
    chk({tag, "_regs"}, reg_out, model);
    cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Drives a byte into the same cycle in which the synchronised cs edge is seen.
  task automatic collide(input logic [7:0] b, input logic exp_stb, input logic [3:0] exp_addr,
                         input logic [7:0] exp_len, input logic exp_err, input string tag);
    @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (exp_stb) model[exp_addr*8 +: 8] = b;
    chk({tag, "_done"}, 128'(frame_done), 128'(1));
    chk({tag, "_stb"}, 128'(wr_strobe), 128'(exp_stb));
    chk({tag, "_len"}, 128'(frame_len), 128'(exp_len));
    chk({tag, "_err"}, 128'(frame_err), 128'(exp_err));
    chk({tag, "_regs"}, reg_out, model);
    $display("tb: collide %s rx=%02h strobe=%0b len=%0d err=%0b", tag, b, wr_strobe, frame_len, frame_err);
    @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model    = '0;
    rst_n    = 1'b0;
    cs       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_regs", reg_out, 128'(0));
    chk("rst_stb", 128'(wr_strobe), 128'(0));
    chk("rst_addr", 128'(wr_addr), 128'(0));
    chk("rst_data", 128'(wr_data), 128'(0));
    chk("rst_done", 128'(frame_done), 128'(0));
    chk("rst_len", 128'(frame_len), 128'(0));
    chk("rst_err", 128'(frame_err), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);

    // Basic write frame
    send_byte(8'h83, 1'b0, 4'd0, "w_hdr");
    send_byte(8'hAA, 1'b1, 4'd3, "w_d0");
    send_byte(8'hBB, 1'b1, 4'd4, "w_d1");
    end_frame(8'd2, 1'b0, "w_end");

    // Address wrap 15 -> 0
    send_byte(8'h8F, 1'b0, 4'd0, "wrap_hdr");
    send_byte(8'h11, 1'b1, 4'd15, "wrap_d0");
    send_byte(8'h22, 1'b1, 4'd0, "wrap_d1");
    send_byte(8'h33, 1'b1, 4'd1, "wrap_d2");
    end_frame(8'd3, 1'b0, "wrap_end");

    // Bad headers: read bit, then out-of-range address
    send_byte(8'h05, 1'b0, 4'd0, "rd_hdr");
    send_byte(8'h55, 1'b0, 4'd0, "rd_d0");
    end_frame(8'd0, 1'b1, "rd_end");
    send_byte(8'h90, 1'b0, 4'd0, "oor_hdr");
    send_byte(8'h55, 1'b0, 4'd0, "oor_d0");
    end_frame(8'd0, 1'b1, "oor_end");

    // Empty frame and header-only frame
    end_frame(8'd0, 1'b0, "empty_end");
    send_byte(8'h87, 1'b0, 4'd0, "ho_hdr");
    end_frame(8'd0, 1'b0, "ho_end");

    // Back-to-back frames
    send_byte(8'h81, 1'b0, 4'd0, "b2b_hdr1");
    send_byte(8'h01, 1'b1, 4'd1, "b2b_d1");
    end_frame(8'd1, 1'b0, "b2b_end1");
    send_byte(8'h82, 1'b0, 4'd0, "b2b_hdr2");
    send_byte(8'h02, 1'b1, 4'd2, "b2b_d2");
    end_frame(8'd1, 1'b0, "b2b_end2");

    // Data byte colliding with end of frame, then next frame decodes a header
    send_byte(8'h80, 1'b0, 4'd0, "col_hdr");
    collide(8'h77, 1'b1, 4'd0, 8'd1, 1'b0, "col_data");
    send_byte(8'h85, 1'b0, 4'd0, "col_nhdr");
    send_byte(8'h66, 1'b1, 4'd5, "col_nd0");
    end_frame(8'd1, 1'b0, "col_nend");

    // Bad header colliding with end of frame
    collide(8'h05, 1'b0, 4'd0, 8'd0, 1'b1, "colhdr");

    // Asynchronous reset in the middle of a write frame
    send_byte(8'h80, 1'b0, 4'd0, "rst_hdr");
    send_byte(8'h12, 1'b1, 4'd0, "rst_d0");
    #2;
    rst_n = 1'b0;
    model = '0;
    #1;
    chk("mid_rst_regs", reg_out, 128'(0));
    chk("mid_rst_stb", 128'(wr_strobe), 128'(0));
    chk("mid_rst_len", 128'(frame_len), 128'(0));
    $display("tb: async reset mid-frame regs=%0h", reg_out);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h84, 1'b0, 4'd0, "post_hdr");
    send_byte(8'h9C, 1'b1, 4'd4, "post_d0");
    end_frame(8'd1, 1'b0, "post_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
